cla_seq_add64: RTL and testbench

Multi-cycle 64-bit add/subtract unit that time-multiplexes one internal 16-bit carry-lookahead adder slice over four cycles. A registered carry links the slices. It sits between a valid/ready operand producer and a valid/ready result consumer, where area matters more than throughput. It produces the 64-bit sum plus carry, signed-overflow and zero flags.

---
 rtl/cla_seq_add64_if.sv | 46 ++++
 rtl/cla_seq_add64.sv | 169 ++++++++++++++++
 tb/tb_cla_seq_add64.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_add64_if.sv
// Operand/result handshake bundle for cla_seq_add64.
// slave: the adder side; master: the producer/consumer side.
interface cla_seq_add64_if;
  logic        valid_in;
  logic        ready_out;
  logic [63:0] A_in;
  logic [63:0] B_in;
  logic        C_in;
  logic        sub_in;
  logic        valid_out;
  logic        ready_in;
  logic [63:0] S_out;
  logic        C_out;
  logic        V_out;
  logic        Z_out;

  modport slave (
    input  valid_in,
    input  A_in,
    input  B_in,
    input  C_in,
    input  sub_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output S_out,
    output C_out,
    output V_out,
    output Z_out
  );

  modport master (
    output valid_in,
    output A_in,
    output B_in,
    output C_in,
    output sub_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  S_out,
    input  C_out,
    input  V_out,
    input  Z_out
  );
endinterface

// File: rtl/cla_seq_add64.sv
// 64-bit add/sub: one 16-bit CLA slice reused over 4 cycles.
// Ports: clk_in, rst_in (async high), bus (cla_seq_add64_if.slave).

module cla_seq_add64_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a | b;
    gg = '0;
    pg = '0;
    gc = '0;
    c  = '0;
    // nibble-level generate/propagate
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // second-level lookahead across nibbles
    gc[0] = ci;
    gc[1] = gg[0] | (pg[0] & ci);
    gc[2] = gg[1] | (pg[1] & gg[0])
          | (pg[1] & pg[0] & ci);
    gc[3] = gg[2] | (pg[2] & gg[1])
          | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & ci);
    gc[4] = gg[3] | (pg[3] & gg[2])
          | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & ci);
    // bit carries inside each nibble
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1]
                  & p[4*k] & gc[k]);
    end
    sum = a ^ b ^ c;
    co  = gc[4];
  end
endmodule

module cla_seq_add64 (
  input  logic           clk_in,
  input  logic           rst_in,
  cla_seq_add64_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cnt_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        carry_q;
  logic [63:0] s_q;
  logic        c_q;
  logic        v_q;
  logic        z_q;
  logic        valid_q;

  logic [5:0]  lsb;
  logic [15:0] a_sl;
  logic [15:0] b_sl;
  logic [15:0] sum_sl;
  logic        co_sl;
  logic        accept;
  logic        last;

  assign lsb    = {cnt_q, 4'b0000};
  assign a_sl   = a_q[lsb +: 16];
  assign b_sl   = b_q[lsb +: 16];
  assign accept = (state_q == IDLE)
                & bus.valid_in;
  assign last   = (state_q == RUN)
                & (cnt_q == 2'd3);

  cla_seq_add64_cla16 u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .ci  (carry_q),
    .sum (sum_sl),
    .co  (co_sl)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_in) state_d = RUN;
      RUN:     if (cnt_q == 2'd3) state_d = DONE;
      DONE:    if (bus.ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.A_in;
        b_q     <= bus.sub_in ? ~bus.B_in
                              : bus.B_in;
        // subtraction forces the +1 of A+~B+1
        carry_q <= bus.sub_in | bus.C_in;
        cnt_q   <= '0;
      end
      if (state_q == RUN) begin
        s_q[lsb +: 16] <= sum_sl;
        carry_q        <= co_sl;
        cnt_q          <= cnt_q + 2'd1;
      end
      if (last) begin
        c_q     <= co_sl;
        // carry into bit 63 xor carry out of it
        v_q     <= a_q[63] ^ b_q[63]
                 ^ sum_sl[15] ^ co_sl;
        z_q     <= ~|{sum_sl, s_q[47:0]};
        valid_q <= 1'b1;
      end
      if ((state_q == DONE) && bus.ready_in)
        valid_q <= 1'b0;
    end
  end

  assign bus.ready_out = (state_q == IDLE);
  assign bus.valid_out = valid_q;
  assign bus.S_out     = s_q;
  assign bus.C_out     = c_q;
  assign bus.V_out     = v_q;
  assign bus.Z_out     = z_q;
endmodule

// File: tb/tb_cla_seq_add64.sv
// Directed + randomized bench for cla_seq_add64.
// Checks results, flags, latency, backpressure, reset abort.
module tb_cla_seq_add64;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  cla_seq_add64_if bus_if ();

  cla_seq_add64 dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h",
                  tag, got, exp);
  endtask

  function automatic void model(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c,
    input  logic        s,
    output logic [63:0] es,
    output logic        ec,
    output logic        ev,
    output logic        ez);
    logic [63:0] bb;
    logic [64:0] r;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb}
       + {64'd0, (s | c)};
    es = r[63:0];
    ec = r[64];
    ev = (a[63] == bb[63]) && (r[63] != a[63]);
    ez = (r[63:0] == 64'd0);
  endfunction

  task automatic do_op(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        c,
    input logic        s,
    input logic [63:0] es,
    input logic        ec,
    input logic        ev,
    input logic        ez,
    input int          gap,
    input int          hold);
    int n;
    int lat;
    bit seen;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    n = 0;
    while (!bus_if.ready_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".rdy"}, 64'(bus_if.ready_out), 64'd1);
    bus_if.A_in     = a;
    bus_if.B_in     = b;
    bus_if.C_in     = c;
    bus_if.sub_in   = s;
    bus_if.valid_in = 1'b1;
    @(posedge clk); #1;
    bus_if.valid_in = 1'b0;
    bus_if.A_in     = {$urandom, $urandom};
    bus_if.B_in     = {$urandom, $urandom};
    bus_if.C_in     = 1'($urandom);
    bus_if.sub_in   = 1'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (bus_if.valid_out) seen = 1'b1;
    end
    check({tag, ".lat"}, 64'(lat), 64'd4);
    check({tag, ".S"}, bus_if.S_out, es);
    check({tag, ".C"}, 64'(bus_if.C_out), 64'(ec));
    check({tag, ".V"}, 64'(bus_if.V_out), 64'(ev));
    check({tag, ".Z"}, 64'(bus_if.Z_out), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".holdS"}, bus_if.S_out, es);
      check({tag, ".holdV"},
            64'(bus_if.valid_out), 64'd1);
    end
    bus_if.ready_in = 1'b1;
    @(posedge clk); #1;
    bus_if.ready_in = 1'b0;
    check({tag, ".drop"},
          64'(bus_if.valid_out), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rs;
    logic [63:0] es;
    logic        ec;
    logic        ev;
    logic        ez;
    int          vcnt;

    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus_if.valid_in = 1'b0;
    bus_if.ready_in = 1'b0;
    bus_if.A_in     = '0;
    bus_if.B_in     = '0;
    bus_if.C_in     = 1'b0;
    bus_if.sub_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 64'(bus_if.ready_out), 64'd1);
    check("rst.valid", 64'(bus_if.valid_out), 64'd0);
    check("rst.S", bus_if.S_out, 64'd0);
    check("rst.flags",
          64'({bus_if.C_out, bus_if.V_out,
               bus_if.Z_out}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("xslice", 64'h0000_0000_0000_FFFF, 64'd1,
          1'b0, 1'b0, 64'h0000_0000_0001_0000,
          1'b0, 1'b0, 1'b0, 0, 0);
    do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
          1'b1, 1'b0, 64'd0,
          1'b1, 1'b0, 1'b1, 1, 0);
    do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          1'b0, 1'b0, 64'h8000_0000_0000_0000,
          1'b0, 1'b1, 1'b0, 0, 1);
    do_op("sub57", 64'd5, 64'd7,
          1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE,
          1'b0, 1'b0, 1'b0, 2, 0);
    do_op("sub75", 64'd7, 64'd5,
          1'b1, 1'b1, 64'd2,
          1'b1, 1'b0, 1'b0, 0, 0);
    do_op("subovf", 64'h8000_0000_0000_0000, 64'd1,
          1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
          1'b1, 1'b1, 1'b0, 0, 0);
    do_op("subzero", 64'd5, 64'd5,
          1'b0, 1'b1, 64'd0,
          1'b1, 1'b0, 1'b1, 0, 0);
    do_op("mix", 64'h1234_5678_9ABC_DEF0,
          64'h0FED_CBA9_8765_4321,
          1'b0, 1'b0, 64'h2222_2222_2222_2211,
          1'b0, 1'b0, 1'b0, 0, 0);
    do_op("negovf", 64'h8000_0000_0000_0000,
          64'h8000_0000_0000_0000,
          1'b0, 1'b0, 64'd0,
          1'b1, 1'b1, 1'b1, 0, 0);

    // backpressure with a competing request
    bus_if.A_in     = 64'd100;
    bus_if.B_in     = 64'd23;
    bus_if.C_in     = 1'b0;
    bus_if.sub_in   = 1'b0;
    bus_if.valid_in = 1'b1;
    @(posedge clk); #1;
    bus_if.A_in   = 64'hDEAD;
    bus_if.B_in   = 64'hBEEF;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("bp.valid", 64'(bus_if.valid_out), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.S", bus_if.S_out, 64'd123);
      check("bp.busy",
            64'({bus_if.valid_out,
                 bus_if.ready_out}), 64'b10);
    end
    bus_if.valid_in = 1'b0;
    bus_if.ready_in = 1'b1;
    @(posedge clk); #1;
    bus_if.ready_in = 1'b0;
    check("bp.idle",
          64'({bus_if.valid_out,
               bus_if.ready_out}), 64'b01);
    check("bp.keepS", bus_if.S_out, 64'd123);

    // reset abort with two slices finished
    bus_if.A_in     = 64'h1111_1111_1111_1111;
    bus_if.B_in     = 64'h1111_1111_1111_1111;
    bus_if.C_in     = 1'b0;
    bus_if.sub_in   = 1'b0;
    bus_if.valid_in = 1'b1;
    @(posedge clk); #1;
    bus_if.valid_in = 1'b0;
    bus_if.ready_in = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("ab.part", 64'(bus_if.S_out[31:0]),
          64'h2222_2222);
    rst = 1'b1;
    #1;
    check("ab.state",
          64'({bus_if.valid_out,
               bus_if.ready_out}), 64'b01);
    check("ab.S", bus_if.S_out, 64'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus_if.valid_out) vcnt++;
    end
    check("ab.noresult", 64'(vcnt), 64'd0);
    bus_if.ready_in = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec, ev, ez);
      do_op("rnd", ra, rb, rc, rs, es, ec, ev, ez,
            $urandom_range(0, 2),
            $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
